// File: rtl/sum_range_pkg.sv
// Shared types and constants for the range-sum engine.
package sum_range_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CHECK,
    ADD,
    DONE
  } state_t;

  // A zero step would never advance the term, so it is replaced by this value.
  localparam int unsigned STEP_ZERO_SUB = 1;

endpackage

// File: rtl/sum_range_dp.sv
// Range-sum datapath: term/bound/step/sum registers, carry adder, bound compare
// and saturation.
module sum_range_dp
  import sum_range_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             add,
  input  logic             satHold,
  input  logic [WIDTH-1:0] startNum,
  input  logic [WIDTH-1:0] endNum,
  input  logic [WIDTH-1:0] step,
  output logic             aLeEnd,
  output logic             carry,
  output logic [WIDTH-1:0] sum
);

  // The term register has one extra bit so stepping past 2^WIDTH ends the loop.
  logic [WIDTH:0]   aReg;
  logic [WIDTH-1:0] endReg;
  logic [WIDTH-1:0] stepReg;
  logic [WIDTH-1:0] sumReg;
  logic [WIDTH-1:0] addSum;
  logic [WIDTH-1:0] stepSel;

  assign {carry, addSum} = {1'b0, sumReg} + {1'b0, aReg[WIDTH-1:0]};
  assign aLeEnd  = (aReg <= {1'b0, endReg});
  assign stepSel = (step == '0) ? WIDTH'(STEP_ZERO_SUB) : step;
  assign sum     = sumReg;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      aReg    <= '0;
      endReg  <= '0;
      stepReg <= '0;
      sumReg  <= '0;
    end else begin
      if (load) begin
        aReg    <= {1'b0, startNum};
        endReg  <= endNum;
        stepReg <= stepSel;
      end
      if (clear) begin
        sumReg <= '0;
      end
      if (add) begin
        aReg <= aReg + {1'b0, stepReg};
        // Once saturated, the sum is pinned at all-ones for the rest of the run.
        if ((SATURATE != 0) && (carry || satHold)) begin
          sumReg <= '1;
        end else begin
          sumReg <= addSum;
        end
      end
    end
  end

endmodule

// File: rtl/sum_range_engine.sv
// Range-sum engine top: control FSM, start/busy/done handshake, published result.
// Handshake: iStart is accepted only in IDLE; oBusy is high from the accept edge
// until the cycle after the single-cycle oDone pulse, when oSum/oOvf are valid.
module sum_range_engine
  import sum_range_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iStartNum,
  input  logic [WIDTH-1:0] iEndNum,
  input  logic [WIDTH-1:0] iStep,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oSum,
  output logic             oOvf
);

  state_t state;
  state_t stateNext;

  logic             load;
  logic             clear;
  logic             add;
  logic             publish;
  logic             aLeEnd;
  logic             carry;
  logic             ovfAcc;
  logic [WIDTH-1:0] dpSum;

  sum_range_dp #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_dp (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .load    (load),
    .clear   (clear),
    .add     (add),
    .satHold (ovfAcc),
    .startNum(iStartNum),
    .endNum  (iEndNum),
    .step    (iStep),
    .aLeEnd  (aLeEnd),
    .carry   (carry),
    .sum     (dpSum)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      ovfAcc <= 1'b0;
      oSum   <= '0;
      oOvf   <= 1'b0;
    end else begin
      state <= stateNext;
      if (clear) begin
        ovfAcc <= 1'b0;
      end else if (add && carry) begin
        ovfAcc <= 1'b1;
      end
      // Result lands on the edge entering DONE so it is valid alongside oDone.
      if (publish) begin
        oSum <= dpSum;
        oOvf <= ovfAcc;
      end
    end
  end

  always_comb begin
    stateNext = state;
    load      = 1'b0;
    clear     = 1'b0;
    add       = 1'b0;
    publish   = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          load      = 1'b1;
          stateNext = INIT;
        end
      end
      INIT: begin
        clear     = 1'b1;
        stateNext = CHECK;
      end
      CHECK: begin
        if (aLeEnd) begin
          stateNext = ADD;
        end else begin
          publish   = 1'b1;
          stateNext = DONE;
        end
      end
      ADD: begin
        add       = 1'b1;
        stateNext = CHECK;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign oBusy = (state != IDLE);
  assign oDone = (state == DONE);

endmodule

// File: tb/tb_sum_range_engine.sv
// Bench for sum_range_engine: a wrapping and a saturating instance share stimulus,
// checked against a table of known runs and an arithmetic reference model.
module tb_sum_range_engine;

  localparam int W = 8;

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b0;
  logic         iStart = 1'b0;
  logic [W-1:0] iStartNum = '0;
  logic [W-1:0] iEndNum = '0;
  logic [W-1:0] iStep = '0;

  logic         busyW, doneW, ovfW;
  logic [W-1:0] sumW;
  logic         busyS, doneS, ovfS;
  logic [W-1:0] sumS;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int s;
    int e;
    int st;
    int sumWrap;
    int sumSat;
    int ovf;
    int cyc;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 iClk = ~iClk;

  sum_range_engine #(.WIDTH(W), .SATURATE(0)) dutWrap (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStartNum(iStartNum),
    .iEndNum(iEndNum), .iStep(iStep), .oBusy(busyW), .oDone(doneW),
    .oSum(sumW), .oOvf(ovfW)
  );

  sum_range_engine #(.WIDTH(W), .SATURATE(1)) dutSat (
    .iClk(iClk), .iRst_n(iRst_n), .iStart(iStart), .iStartNum(iStartNum),
    .iEndNum(iEndNum), .iStep(iStep), .oBusy(busyS), .oDone(doneS),
    .oSum(sumS), .oOvf(ovfS)
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: walk the terms with plain integers, no width limits.
  task automatic model(input int s, input int e, input int st,
                       output int sumWrap, output int sumSat,
                       output int ovf, output int cyc);
    longint total = 0;
    int n = 0;
    int stp = (st == 0) ? 1 : st;
    for (int t = s; t <= e; t += stp) begin
      total += t;
      n++;
    end
    sumWrap = int'(total % (1 << W));
    sumSat  = (total >= (1 << W)) ? (1 << W) - 1 : int'(total);
    ovf     = (total >= (1 << W)) ? 1 : 0;
    cyc     = 2 * n + 2;
  endtask

  // ---------------- driver tasks ----------------
  // Called #1 after an edge; returns #1 after the accepting edge (cycle 0).
  task automatic startRun(input int s, input int e, input int st);
    iStartNum = W'(s);
    iEndNum   = W'(e);
    iStep     = W'(st);
    iStart    = 1'b1;
    @(posedge iClk); #1;
    iStart    = 1'b0;
    // Operands are latched; scrambling the inputs must not matter.
    iStartNum = W'($urandom_range(0, 255));
    iEndNum   = W'($urandom_range(0, 255));
    iStep     = W'($urandom_range(0, 255));
  endtask

  task automatic waitDone(input int pokeCycle, output int cyc);
    int busyLow = 0;
    int sumMoved = 0;
    logic got = 1'b0;
    logic [W-1:0] held = sumW;
    cyc = 0;
    for (int c = 1; c <= 1000; c++) begin
      iStart = (c == pokeCycle);
      if (c == pokeCycle) begin
        iStartNum = 8'd5;
        iEndNum   = 8'd2;
      end
      @(posedge iClk); #1;
      if (doneW) begin
        cyc = c;
        got = 1'b1;
        break;
      end
      if (!busyW) busyLow++;
      if (sumW != held) sumMoved++;
    end
    iStart = 1'b0;
    chk("done_seen", int'(got), 1);
    chk("busy_during_run", busyLow, 0);
    chk("sum_held_during_run", sumMoved, 0);
    chk("busy_at_done", int'(busyW), 1);
    chk("sat_done_aligned", int'(doneS), 1);
  endtask

  task automatic runAndCheck(input int s, input int e, input int st,
                             input int sumWrap, input int sumSat,
                             input int ovf, input int cyc, input int pokeCycle);
    int gotCyc;
    logic [W-1:0] expSum;
    exp_q.push_back(W'(sumWrap));
    startRun(s, e, st);
    waitDone(pokeCycle, gotCyc);
    chk("done_cycle", gotCyc, cyc);
    expSum = exp_q.pop_front();
    chk("sum_wrap", int'(sumW), int'(expSum));
    chk("ovf_wrap", int'(ovfW), ovf);
    chk("sum_sat", int'(sumS), sumSat);
    chk("ovf_sat", int'(ovfS), ovf);
    @(posedge iClk); #1;
    chk("done_one_cycle", int'(doneW), 0);
    chk("idle_after_done", int'(busyW), 0);
    chk("sum_held_after", int'(sumW), sumWrap);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int sw, ss, ov, cy, gotCyc;

    vecs.push_back('{0,   10,  1, 55,  55,  0, 24});
    vecs.push_back('{1,   10,  3, 22,  22,  0, 10});
    vecs.push_back('{3,   5,   0, 12,  12,  0, 8});
    vecs.push_back('{0,   30,  1, 209, 255, 1, 64});
    vecs.push_back('{250, 255, 4, 248, 255, 1, 6});
    vecs.push_back('{5,   2,   1, 0,   0,   0, 2});
    vecs.push_back('{255, 255, 1, 255, 255, 0, 4});
    vecs.push_back('{0,   0,   0, 0,   0,   0, 4});

    repeat (2) @(posedge iClk);
    #1;
    chk("reset_busy", int'(busyW), 0);
    chk("reset_done", int'(doneW), 0);
    chk("reset_sum", int'(sumW), 0);
    chk("reset_ovf", int'(ovfW), 0);
    @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    foreach (vecs[i]) begin
      runAndCheck(vecs[i].s, vecs[i].e, vecs[i].st, vecs[i].sumWrap,
                  vecs[i].sumSat, vecs[i].ovf, vecs[i].cyc, 0);
    end

    // Start pulsed mid-run with different operands is ignored.
    runAndCheck(0, 10, 1, 55, 55, 0, 24, 5);

    // Start held through the DONE cycle is ignored, then accepted a cycle later.
    startRun(3, 5, 1);
    waitDone(0, gotCyc);
    chk("b2b_first_sum", int'(sumW), 12);
    iStartNum = 8'd0;
    iEndNum   = 8'd10;
    iStep     = 8'd1;
    iStart    = 1'b1;
    @(posedge iClk); #1;
    chk("start_in_done_ignored", int'(busyW), 0);
    @(posedge iClk); #1;
    iStart = 1'b0;
    chk("b2b_accepted", int'(busyW), 1);
    waitDone(0, gotCyc);
    chk("b2b_done_cycle", gotCyc, 24);
    chk("b2b_sum", int'(sumW), 55);

    // Reset mid-run aborts without a done pulse.
    @(posedge iClk); #1;
    startRun(0, 30, 1);
    repeat (7) @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busyW), 0);
    chk("abort_sum", int'(sumW), 0);
    chk("abort_ovf", int'(ovfW), 0);
    chk("abort_sat_sum", int'(sumS), 0);
    repeat (3) begin
      @(posedge iClk); #1;
      chk("abort_no_done", int'(doneW), 0);
    end
    @(negedge iClk);
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    runAndCheck(0, 10, 1, 55, 55, 0, 24, 0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 40; r++) begin
      int s = $urandom_range(0, 255);
      int e = $urandom_range(0, 255);
      int st = $urandom_range(0, 24);
      model(s, e, st, sw, ss, ov, cy);
      runAndCheck(s, e, st, sw, ss, ov, cy, (r % 4 == 0) ? 3 : 0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sum_range_engine.md
Name: sum_range_engine

Overview:
Self-contained range-sum engine. FSM and datapath in one block: on a start pulse it accumulates every term from iStartNum to iEndNum, stepping by iStep, into a WIDTH-bit sum.
Generalises the fixed 8-bit 0..10 summing datapath:
- runtime bounds and step
- parametrised width
- start/busy/done handshake
- overflow detection with wrap or saturate mode
Sits beside the dedicated-CPU datapaths as a reusable accumulate unit.

Parameters:
WIDTH, 8, bit width of bounds, step and sum.
SATURATE, 0, 0 = sum wraps modulo 2^WIDTH; 1 = sum clamps at all-ones.

Ports:
iClk  in  1  system clock, rising edge.
iRst_n  in  1  asynchronous active-low reset.
iStart  in  1  start request, sampled in IDLE only.
iStartNum  in  WIDTH  first term, captured on accepted start.
iEndNum  in  WIDTH  inclusive upper bound, captured on accepted start.
iStep  in  WIDTH  increment, captured on accepted start; 0 is treated as 1.
oBusy  out  1  high in every state except IDLE.
oDone  out  1  one-cycle pulse when the result is published.
oSum  out  WIDTH  result register; holds its value between runs.
oOvf  out  1  overflow flag of the last run; published with oSum.

Behaviour:
- Reset (iRst_n = 0, asynchronous): state to IDLE; all registers (A, Sum, End, Step, oSum, oOvf, ovf_acc) clear; oBusy = 0, oDone = 0. Reset mid-run aborts the run; no done pulse.
- States: IDLE, INIT, CHECK, ADD, DONE.
- IDLE: iStart = 1 moves to INIT. Inputs are captured on this edge: A <= iStartNum (WIDTH+1 bits, MSB 0), End <= iEndNum, Step <= (iStep == 0 ? 1 : iStep).
- INIT: Sum <= 0, ovf_acc <= 0; go to CHECK.
- CHECK: if A <= {0, End} (full WIDTH+1 compare), go to ADD; otherwise go to DONE.
- ADD:
  - Sum <= Sum + A[WIDTH-1:0].
  - On carry out, set ovf_acc. If SATURATE = 1, Sum <= all-ones, and stays saturated for the rest of the run.
  - A <= A + Step in WIDTH+1 bits, so a wrap of A past 2^WIDTH ends the loop instead of looping forever.
  - Go to CHECK.
- DONE: oSum <= Sum, oOvf <= ovf_acc, oDone = 1 for exactly this cycle; go to IDLE.
- Latency: for N terms, oDone is high in cycle 2N+2 after the accepted iStart edge (cycle 0). N = 0 (start > end) gives done at cycle 2 and sum 0.
- iStart while oBusy = 1 is ignored; no queuing. iStart high in the DONE cycle is also ignored. Back-to-back starts are therefore accepted at the earliest one cycle after oDone.
- Input changes while busy have no effect (operands are latched).
- oSum and oOvf change only in DONE; they are stable from oDone until the next DONE.
- All comparisons and additions are unsigned.

Decomposition:
- Package sum_range_pkg: state_t enum (IDLE, INIT, CHECK, ADD, DONE) and the constant for the step-zero substitute (1).
- Sub-module sum_range_dp: A/Sum/End/Step registers, adder with carry, comparator and saturation logic. Control inputs are the load and select strobes; status outputs are a_le_end and carry.
- The top module holds the FSM, the handshake and the output registers.

Test Plan:
- Start=0, End=10, Step=1, WIDTH=8 -> oDone at cycle 24; oSum = 55; oOvf = 0; oBusy high cycles 1-24.
- Start=1, End=10, Step=3 -> terms 1, 4, 7, 10; oSum = 22; oDone at cycle 10. Step=0 with Start=3, End=5 -> oSum = 12.
- Start=0, End=30, Step=1, SATURATE=0 -> oSum = 209 (465 mod 256), oOvf = 1. Same with SATURATE=1 -> oSum = 255, oOvf = 1.
- Start=250, End=255, Step=4 -> terms 250, 254; A wraps to 258 and the loop ends; oSum = 248, oOvf = 1; oDone at cycle 6.
- Start=5, End=2 -> oSum = 0, oOvf = 0, oDone at cycle 2. Then iStart pulsed at cycle 5 of a 0..10 run -> ignored; result still 55.
- Assert iRst_n = 0 mid-run at cycle 7 -> immediately oBusy = 0, oSum = 0, no oDone. A new start after release gives the correct result.
